// File: rtl/kalman_step_sequencer.sv
// Sequences one Kalman filter iteration per accepted sample: prediction/gain strobes,
// update strobe, then estimate handoff, with a watchdog on every datapath wait.
module kalman_step_sequencer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clk_en,
  input  logic             i_sample_valid,
  output logic             o_sample_ready,
  output logic             o_start_prediction,
  output logic             o_start_gain,
  input  logic             i_ready_prediction,
  input  logic             i_gain_ready,
  output logic             o_start_update,
  input  logic             i_ready_update,
  output logic             o_est_valid,
  input  logic             i_est_ready,
  output logic [CNT_W-1:0] o_iter_count,
  output logic             o_busy,
  output logic             o_timeout_err,
  input  logic             i_clear_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRED    = 3'd1,
    S_WAIT_PG = 3'd2,
    S_UPD     = 3'd3,
    S_WAIT_U  = 3'd4,
    S_OUT     = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_pred_done;
  logic               r_gain_done;
  logic               w_pred_done_nxt;
  logic               w_gain_done_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic [TMR_W-1:0]   w_timer_inc;
  logic [CNT_W-1:0]   r_iter;
  logic [CNT_W-1:0]   w_iter_nxt;
  logic               w_blank;
  logic               w_timeout;
  logic               w_pred_seen;
  logic               w_gain_seen;

  // Timer value zero marks the first cycle of a wait, which doubles as the blanking cycle.
  assign w_timer_inc = r_timer + TMR_W'(1);
  assign w_timeout   = (w_timer_inc == TMR_W'(TIMEOUT));
  assign w_blank     = (r_timer == {TMR_W{1'b0}});
  assign w_pred_seen = r_pred_done | i_ready_prediction;
  assign w_gain_seen = r_gain_done | i_gain_ready;

  // Next-state, done-flag, watchdog and iteration-count logic
  always_comb begin
    w_state_nxt     = r_state;
    w_pred_done_nxt = r_pred_done;
    w_gain_done_nxt = r_gain_done;
    w_timer_nxt     = r_timer;
    w_iter_nxt      = r_iter;
    case (r_state)
      S_IDLE: begin
        if (i_sample_valid && o_sample_ready) begin
          w_state_nxt = S_PRED;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRED: begin
        w_state_nxt     = S_WAIT_PG;
        w_pred_done_nxt = 1'b0;
        w_gain_done_nxt = 1'b0;
        w_timer_nxt     = {TMR_W{1'b0}};
      end
      S_WAIT_PG: begin
        w_timer_nxt = w_timer_inc;
        if (!w_blank) begin
          w_pred_done_nxt = w_pred_seen;
          w_gain_done_nxt = w_gain_seen;
        end else begin
          w_pred_done_nxt = r_pred_done;
          w_gain_done_nxt = r_gain_done;
        end
        // A completing ready in the same cycle takes priority over the watchdog.
        if (!w_blank && w_pred_seen && w_gain_seen) begin
          w_state_nxt = S_UPD;
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_WAIT_PG;
        end
      end
      S_UPD: begin
        w_state_nxt = S_WAIT_U;
        w_timer_nxt = {TMR_W{1'b0}};
      end
      S_WAIT_U: begin
        w_timer_nxt = w_timer_inc;
        if (!w_blank && i_ready_update) begin
          w_state_nxt = S_OUT;
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_WAIT_U;
        end
      end
      S_OUT: begin
        if (i_est_ready) begin
          w_state_nxt = S_IDLE;
          w_iter_nxt  = r_iter + CNT_W'(1);
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      S_ERR: begin
        if (i_clear_err) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, flag and registered-output update; outputs are decoded from the next state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state            <= S_IDLE;
      r_pred_done        <= 1'b0;
      r_gain_done        <= 1'b0;
      r_timer            <= {TMR_W{1'b0}};
      r_iter             <= {CNT_W{1'b0}};
      o_sample_ready     <= 1'b0;
      o_start_prediction <= 1'b0;
      o_start_gain       <= 1'b0;
      o_start_update     <= 1'b0;
      o_est_valid        <= 1'b0;
      o_busy             <= 1'b0;
      o_timeout_err      <= 1'b0;
      o_iter_count       <= {CNT_W{1'b0}};
    end else if (i_clk_en) begin
      r_state            <= w_state_nxt;
      r_pred_done        <= w_pred_done_nxt;
      r_gain_done        <= w_gain_done_nxt;
      r_timer            <= w_timer_nxt;
      r_iter             <= w_iter_nxt;
      o_sample_ready     <= (w_state_nxt == S_IDLE);
      o_start_prediction <= (w_state_nxt == S_PRED);
      o_start_gain       <= (w_state_nxt == S_PRED);
      o_start_update     <= (w_state_nxt == S_UPD);
      o_est_valid        <= (w_state_nxt == S_OUT);
      o_busy             <= (w_state_nxt != S_IDLE);
      o_timeout_err      <= (w_state_nxt == S_ERR);
      o_iter_count       <= w_iter_nxt;
    end else begin
      r_state            <= r_state;
      r_pred_done        <= r_pred_done;
      r_gain_done        <= r_gain_done;
      r_timer            <= r_timer;
      r_iter             <= r_iter;
      o_sample_ready     <= o_sample_ready;
      o_start_prediction <= o_start_prediction;
      o_start_gain       <= o_start_gain;
      o_start_update     <= o_start_update;
      o_est_valid        <= o_est_valid;
      o_busy             <= o_busy;
      o_timeout_err      <= o_timeout_err;
      o_iter_count       <= o_iter_count;
    end
  end

endmodule
